// File: rtl/axi_sram_slave.sv
// AXI INCR-burst slave backed by a word-addressed RAM; independent read and write FSMs,
// one outstanding transaction per direction, every output driven from a register.
module axi_sram_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024,
  parameter int RD_DELAY   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready
);
  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int BYTE_SH = $clog2(STRB_W);
  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(STRB_W);
  localparam logic [3:0] RD_LAST_CNT = 4'(RD_DELAY - 1);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  rstate_t               r_rstate, w_rstate_nxt;
  logic [3:0]            r_rcnt, w_rcnt_nxt;
  logic [ADDR_WIDTH-1:0] r_raddr, w_raddr_nxt;
  logic [7:0]            r_rlen, w_rlen_nxt, r_rbeat, w_rbeat_nxt;
  logic [ID_WIDTH-1:0]   r_rid, w_rid_nxt;
  logic                  r_arready, w_arready_nxt, r_rvalid, w_rvalid_nxt, r_rlast, w_rlast_nxt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_rd_load;
  logic [IDX_W-1:0]      w_rd_idx;

  wstate_t               r_wstate, w_wstate_nxt;
  logic [ADDR_WIDTH-1:0] r_waddr, w_waddr_nxt;
  logic [7:0]            r_wlen, w_wlen_nxt, r_wbeat, w_wbeat_nxt;
  logic [ID_WIDTH-1:0]   r_wid, w_wid_nxt;
  logic                  r_werr, w_werr_nxt, r_awready, w_awready_nxt, r_wready, w_wready_nxt;
  logic                  r_bvalid, w_bvalid_nxt;
  logic [1:0]            r_bresp, w_bresp_nxt;
  logic                  w_mem_we, w_wlast_exp;
  logic [IDX_W-1:0]      w_wr_idx;

  // Read side: rdata is loaded from the RAM on the edge that presents each beat.
  always_comb begin
    w_rstate_nxt  = r_rstate;
    w_rcnt_nxt    = r_rcnt;
    w_raddr_nxt   = r_raddr;
    w_rlen_nxt    = r_rlen;
    w_rbeat_nxt   = r_rbeat;
    w_rid_nxt     = r_rid;
    w_arready_nxt = r_arready;
    w_rvalid_nxt  = r_rvalid;
    w_rlast_nxt   = r_rlast;
    w_rd_load     = 1'b0;
    unique case (r_rstate)
      R_IDLE: begin
        w_arready_nxt = 1'b1;
        if (arvalid && r_arready) begin
          w_arready_nxt = 1'b0;
          w_rid_nxt     = arid;
          w_raddr_nxt   = araddr;
          w_rlen_nxt    = arlen;
          w_rbeat_nxt   = 8'd0;
          w_rcnt_nxt    = 4'd0;
          if (RD_DELAY == 0) begin
            w_rstate_nxt = R_DATA;
            w_rd_load    = 1'b1;
            w_rvalid_nxt = 1'b1;
            w_rlast_nxt  = (arlen == 8'd0);
          end else begin
            w_rstate_nxt = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_rcnt == RD_LAST_CNT) begin
          w_rstate_nxt = R_DATA;
          w_rd_load    = 1'b1;
          w_rvalid_nxt = 1'b1;
          w_rlast_nxt  = (r_rlen == 8'd0);
        end else begin
          w_rcnt_nxt = r_rcnt + 4'd1;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (r_rlast) begin
            w_rstate_nxt  = R_IDLE;
            w_rvalid_nxt  = 1'b0;
            w_rlast_nxt   = 1'b0;
            w_arready_nxt = 1'b1;
          end else begin
            w_raddr_nxt = r_raddr + ADDR_INC;
            w_rbeat_nxt = r_rbeat + 8'd1;
            w_rd_load   = 1'b1;
            w_rlast_nxt = ((r_rbeat + 8'd1) == r_rlen);
          end
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  assign w_rd_idx = w_raddr_nxt[BYTE_SH +: IDX_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_rcnt    <= '0;
      r_raddr   <= '0;
      r_rlen    <= '0;
      r_rbeat   <= '0;
      r_rid     <= '0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_rcnt    <= w_rcnt_nxt;
      r_raddr   <= w_raddr_nxt;
      r_rlen    <= w_rlen_nxt;
      r_rbeat   <= w_rbeat_nxt;
      r_rid     <= w_rid_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rlast   <= w_rlast_nxt;
      if (w_rd_load) r_rdata <= r_mem[w_rd_idx];
    end
  end

  // Write side: the beat counter, not wlast, closes the burst; wlast disagreement only sets SLVERR.
  assign w_wlast_exp = (r_wbeat == r_wlen);

  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_waddr_nxt   = r_waddr;
    w_wlen_nxt    = r_wlen;
    w_wbeat_nxt   = r_wbeat;
    w_wid_nxt     = r_wid;
    w_werr_nxt    = r_werr;
    w_awready_nxt = r_awready;
    w_wready_nxt  = r_wready;
    w_bvalid_nxt  = r_bvalid;
    w_bresp_nxt   = r_bresp;
    w_mem_we      = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        w_awready_nxt = 1'b1;
        if (awvalid && r_awready) begin
          w_awready_nxt = 1'b0;
          w_wid_nxt     = awid;
          w_waddr_nxt   = awaddr;
          w_wlen_nxt    = awlen;
          w_wbeat_nxt   = 8'd0;
          w_werr_nxt    = 1'b0;
          w_wready_nxt  = 1'b1;
          w_wstate_nxt  = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid && r_wready) begin
          w_mem_we = !rst;
          if (w_wlast_exp) begin
            w_wstate_nxt = W_RESP;
            w_wready_nxt = 1'b0;
            w_bvalid_nxt = 1'b1;
            w_bresp_nxt  = (r_werr || !wlast) ? 2'b10 : 2'b00;
          end else begin
            w_waddr_nxt = r_waddr + ADDR_INC;
            w_wbeat_nxt = r_wbeat + 8'd1;
            w_werr_nxt  = r_werr || wlast;
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          w_wstate_nxt  = W_IDLE;
          w_bvalid_nxt  = 1'b0;
          w_bresp_nxt   = 2'b00;
          w_awready_nxt = 1'b1;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  assign w_wr_idx = r_waddr[BYTE_SH +: IDX_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_waddr   <= '0;
      r_wlen    <= '0;
      r_wbeat   <= '0;
      r_wid     <= '0;
      r_werr    <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_waddr   <= w_waddr_nxt;
      r_wlen    <= w_wlen_nxt;
      r_wbeat   <= w_wbeat_nxt;
      r_wid     <= w_wid_nxt;
      r_werr    <= w_werr_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
    end
  end

  // RAM has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) r_mem[w_wr_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign arready = r_arready;
  assign rid     = r_rid;
  assign rdata   = r_rdata;
  assign rresp   = 2'b00;
  assign rlast   = r_rlast;
  assign rvalid  = r_rvalid;
  assign awready = r_awready;
  assign wready  = r_wready;
  assign bid     = r_wid;
  assign bresp   = r_bresp;
  assign bvalid  = r_bvalid;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: stimulus pushes expected R/B responses, a monitor pops and compares.
module tb_axi_sram_slave;
  localparam int AW = 32, DW = 32, IW = 4, DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [IW-1:0] arid = '0, awid = '0, rid, bid;
  logic [AW-1:0] araddr = '0, awaddr = '0;
  logic [7:0] arlen = '0, awlen = '0;
  logic arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic rready = 1'b1, bready = 1'b1;
  logic arready, awready, wready, rvalid, rlast, bvalid;
  logic [DW-1:0] wdata = '0, rdata;
  logic [DW/8-1:0] wstrb = '0;
  logic [1:0] rresp, bresp;

  always #5 clk = ~clk;

  axi_sram_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH), .RD_DELAY(2)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct packed { logic [IW-1:0] id; logic [DW-1:0] data; logic last; } rexp_t;
  typedef struct packed { logic [IW-1:0] id; logic [1:0] resp; } bexp_t;

  rexp_t rq[$];
  bexp_t bq[$];
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] wbuf [16];
  logic [3:0]    wsb  [16];
  int n_tests = 0, n_fail = 0;
  logic bp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int idx(input logic [AW-1:0] a);
    return int'(a[11:2]);
  endfunction

  task automatic rd_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len, input int npush);
    int t;
    for (int i = 0; i < npush; i++) begin
      rexp_t e;
      e.id = id;
      e.data = model[idx(addr + 32'(4 * i))];
      e.last = (i == len);
      rq.push_back(e);
    end
    @(posedge clk); #1;
    arid = id; araddr = addr; arlen = 8'(len); arvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!arready && t < 100);
    check("ar_accept", 64'(arready), 64'(1));
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wr_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len, input int last_at);
    int t;
    bexp_t b;
    b.id = id;
    b.resp = (last_at == len) ? 2'b00 : 2'b10;
    bq.push_back(b);
    @(posedge clk); #1;
    awid = id; awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!awready && t < 100);
    check("aw_accept", 64'(awready), 64'(1));
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wdata = wbuf[i]; wstrb = wsb[i]; wlast = (i == last_at); wvalid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!wready && t < 100);
      check("w_accept", 64'(wready), 64'(1));
      for (int k = 0; k < 4; k++)
        if (wsb[i][k]) model[idx(addr + 32'(4 * i))][8*k +: 8] = wbuf[i][8*k +: 8];
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((rq.size() != 0 || bq.size() != 0) && t < 1000) begin @(negedge clk); t++; end
    check("drain_pending", 64'(rq.size() + bq.size()), 64'(0));
    repeat (2) @(posedge clk);
  endtask

  // Ready generator: constant 1 unless random backpressure is enabled.
  initial forever begin
    @(posedge clk); #1;
    rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    bready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    rexp_t re;
    bexp_t be;
    forever begin
      @(negedge clk);
      if (rvalid && rready) begin
        if (rq.size() == 0) check("r_unexpected_beat", 64'(rvalid), 64'(0));
        else begin
          re = rq.pop_front();
          check("rdata", 64'(rdata), 64'(re.data));
          check("rid", 64'(rid), 64'(re.id));
          check("rlast", 64'(rlast), 64'(re.last));
          check("rresp", 64'(rresp), 64'(0));
        end
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) check("b_unexpected", 64'(bvalid), 64'(0));
        else begin
          be = bq.pop_front();
          check("bid", 64'(bid), 64'(be.id));
          check("bresp", 64'(bresp), 64'(be.resp));
        end
      end
    end
  end

  initial begin
    #300000;
    n_fail++;
    $display("FAIL watchdog: time limit reached with %0d R and %0d B responses pending", rq.size(), bq.size());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", 64'(arready), 64'(0));
    check("rst_awready", 64'(awready), 64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_bvalid", 64'(bvalid), 64'(0));
    check("rst_wready", 64'(wready), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("arready_before_rise", 64'(arready), 64'(0));
    @(negedge clk);
    check("arready_after_rst", 64'(arready), 64'(1));
    check("awready_after_rst", 64'(awready), 64'(1));

    // Single write, then single read with RD_DELAY=2 timing.
    wbuf[0] = 32'hDEADBEEF; wsb[0] = 4'hF;
    wr_burst(4'h3, 32'h10, 0, 0);
    @(negedge clk);
    check("t1_bvalid_next_cycle", 64'(bvalid), 64'(1));
    drain();
    rd_burst(4'h5, 32'h10, 0, 1);
    @(negedge clk); check("t1_rvalid_T1", 64'(rvalid), 64'(0));
    @(negedge clk); check("t1_rvalid_T2", 64'(rvalid), 64'(0));
    @(negedge clk); check("t1_rvalid_T3", 64'(rvalid), 64'(1));
    check("t1_rdata_T3", 64'(rdata), 64'(32'hDEADBEEF));
    check("t1_rlast_T3", 64'(rlast), 64'(1));
    drain();

    // Partial-strobe merge over 0xFFFFFFFF.
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hFFFFFFFF; wsb[i] = 4'hF; end
    wr_burst(4'h1, 32'h100, 3, 3);
    drain();
    wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
    wsb[2] = 4'h3;
    wr_burst(4'h2, 32'h100, 3, 3);
    drain();
    rd_burst(4'h4, 32'h100, 3, 4);
    drain();

    // 8-beat bursts under random backpressure.
    for (int i = 0; i < 8; i++) begin wbuf[i] = 32'hA5000000 + 32'(i * 32'h01010101); wsb[i] = 4'hF; end
    bp = 1'b1;
    wr_burst(4'h6, 32'h200, 7, 7);
    drain();
    rd_burst(4'h7, 32'h200, 7, 8);
    drain();
    bp = 1'b0;

    // Early wlast -> all beats still written, SLVERR.
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h0BAD0000 + 32'(i); wsb[i] = 4'hF; end
    wr_burst(4'h8, 32'h300, 3, 1);
    drain();
    rd_burst(4'h9, 32'h300, 3, 4);
    drain();

    // Missing wlast on final beat -> SLVERR.
    wbuf[0] = 32'h11112222; wbuf[1] = 32'h33334444;
    wr_burst(4'hC, 32'h380, 1, 5);
    drain();

    // Index wrap from MEM_DEPTH-1 to 0.
    wbuf[0] = 32'hCAFE0001; wbuf[1] = 32'hCAFE0002; wsb[0] = 4'hF; wsb[1] = 4'hF;
    wr_burst(4'hA, 32'((DEPTH - 1) * 4), 1, 1);
    drain();
    rd_burst(4'hB, 32'((DEPTH - 1) * 4), 1, 2);
    rd_burst(4'hD, 32'h0, 0, 1);
    drain();

    // Concurrent AR and AW.
    wbuf[0] = 32'h12345678; wsb[0] = 4'hF;
    fork
      rd_burst(4'hE, 32'h10, 0, 1);
      wr_burst(4'hF, 32'h400, 0, 0);
    join
    drain();
    rd_burst(4'h2, 32'h400, 0, 1);
    drain();

    // Reset while the third beat of an 8-beat read is presented.
    rd_burst(4'h3, 32'h100, 7, 3);
    cnt = 0; t = 0;
    while (cnt < 3 && t < 100) begin
      @(negedge clk); t++;
      if (rvalid && rready) cnt++;
    end
    check("rst_test_beats_seen", 64'(cnt), 64'(3));
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_rvalid", 64'(rvalid), 64'(0));
    check("rst_mid_arready", 64'(arready), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_arready_hold", 64'(arready), 64'(0));
    @(negedge clk);
    check("rst_mid_arready_up", 64'(arready), 64'(1));
    rd_burst(4'h4, 32'h100, 3, 4);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
